// File: rtl/sad_block_min_tracker.sv
// Accumulates partial SADs into candidate-block SADs and tracks the minimum over one search.
// A one-cycle done pulse marks the result.
module sad_block_min_tracker #(
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned ACC_W       = 14,
    parameter int unsigned IDX_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [IDX_W-1:0] num_cand,
    input  logic             sad_valid,
    input  logic [9:0]       sad_in,
    output logic             sad_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] min_sad,
    output logic [IDX_W-1:0] min_index
);

    localparam int unsigned WCNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(BLOCK_WORDS - 1);
    localparam logic [ACC_W-1:0]  ACC_ONES  = {ACC_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e            state;
    logic [ACC_W-1:0]  acc;
    logic [WCNT_W-1:0] word_cnt;
    logic [IDX_W-1:0]  cand_cnt;
    logic [IDX_W-1:0]  num_lat;

    logic [ACC_W-1:0]  cand_sum;
    logic              accept;
    logic              word_last;
    logic              cand_last;

    always_comb begin
        cand_sum  = acc + {{(ACC_W - 10){1'b0}}, sad_in};
        accept    = sad_valid && busy;
        word_last = (word_cnt == WORD_LAST);
        cand_last = (cand_cnt == num_lat - IDX_W'(1));
    end

    assign sad_ready = busy;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            min_sad   <= '0;
            min_index <= '0;
            acc       <= '0;
            word_cnt  <= '0;
            cand_cnt  <= '0;
            num_lat   <= '0;
        end else begin
            done <= 1'b0;
            // start has priority over everything, including a word on the same edge
            if (start) begin
                num_lat   <= num_cand;
                acc       <= '0;
                word_cnt  <= '0;
                cand_cnt  <= '0;
                min_sad   <= ACC_ONES;
                min_index <= '0;
                if (num_cand == '0) begin
                    state <= StFinish;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= StRun;
                    busy  <= 1'b1;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        state <= StIdle;
                    end
                    StRun: begin
                        if (accept) begin
                            if (word_last) begin
                                if (cand_sum < min_sad) begin
                                    min_sad   <= cand_sum;
                                    min_index <= cand_cnt;
                                end
                                acc      <= '0;
                                word_cnt <= '0;
                                cand_cnt <= cand_cnt + IDX_W'(1);
                                if (cand_last) begin
                                    state <= StFinish;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                acc      <= cand_sum;
                                word_cnt <= word_cnt + WCNT_W'(1);
                            end
                        end
                    end
                    StFinish: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sad_block_min_tracker.sv
// Directed and randomized bench for sad_block_min_tracker (BLOCK_WORDS=4, ACC_W=12, IDX_W=8).
// Expected results come from a per-candidate sum/minimum model over a word list.
module tb_sad_block_min_tracker;

    localparam int BW   = 4;
    localparam int AW   = 12;
    localparam int IW   = 8;
    localparam int ONES = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] num_cand = '0;
    logic          sad_valid = 1'b0;
    logic [9:0]    sad_in = '0;
    logic          sad_ready, busy, done;
    logic [AW-1:0] min_sad;
    logic [IW-1:0] min_index;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int words[$];

    sad_block_min_tracker #(.BLOCK_WORDS(BW), .ACC_W(AW), .IDX_W(IW)) dut (
        .Clk(clk), .Reset(rst), .start(start), .num_cand(num_cand),
        .sad_valid(sad_valid), .sad_in(sad_in), .sad_ready(sad_ready),
        .busy(busy), .done(done), .min_sad(min_sad), .min_index(min_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n*BW words from 'words'; mode 0 back-to-back, 1 alternate bubbles, 2 random bubbles.
    task automatic run_search(input string tag, input int n, input int mode);
        int exp_min, exp_idx, s, i, cyc;
        bit early, v;
        exp_min = ONES;
        exp_idx = 0;
        for (int c = 0; c < n; c++) begin
            s = 0;
            for (int k = 0; k < BW; k++) s += words[c*BW + k];
            if (s < exp_min) begin
                exp_min = s;
                exp_idx = c;
            end
        end
        start = 1'b1;
        num_cand = IW'(n);
        tick();
        start = 1'b0;
        if (n == 0) begin
            check({tag, ".done"}, done, 1);
            check({tag, ".busy"}, busy, 0);
            check({tag, ".min_sad"}, min_sad, ONES);
            check({tag, ".min_index"}, min_index, 0);
            sad_valid = 1'b0;
            tick();
            check({tag, ".done_drop"}, done, 0);
            check({tag, ".busy_after"}, busy, 0);
            return;
        end
        check({tag, ".busy_start"}, busy, 1);
        check({tag, ".ready_start"}, sad_ready, 1);
        i = 0;
        cyc = 0;
        early = 0;
        while (i < n*BW && cyc < 2000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else v = ($urandom % 2) == 1;
            sad_valid = v;
            sad_in = v ? 10'(words[i]) : 10'($urandom);
            tick();
            cyc++;
            if (v) i++;
            if (i < n*BW && done === 1'b1) early = 1;
        end
        sad_valid = 1'b0;
        check({tag, ".words_accepted"}, i, n*BW);
        check({tag, ".no_early_done"}, early, 0);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy_on_done"}, busy, 0);
        check({tag, ".min_sad"}, min_sad, exp_min);
        check({tag, ".min_index"}, min_index, exp_idx);
        tick();
        check({tag, ".done_one_cycle"}, done, 0);
        check({tag, ".min_sad_hold"}, min_sad, exp_min);
    endtask

    task automatic set_const(input int n, input int val);
        words.delete();
        for (int i = 0; i < n*BW; i++) words.push_back(val);
    endtask

    initial begin
        int d0, ms;
        #2;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.min_sad", min_sad, 0);
        check("reset.min_index", min_index, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // reset mid-search after 5 accepted words
        start = 1'b1; num_cand = 8'd3;
        tick();
        start = 1'b0;
        sad_valid = 1'b1; sad_in = 10'd9;
        repeat (5) tick();
        sad_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset.busy", busy, 0);
        check("midreset.done", done, 0);
        check("midreset.min_sad", min_sad, 0);
        check("midreset.min_index", min_index, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        set_const(1, 1);
        run_search("after_reset", 1, 0);

        // basic minimum, then the same words with bubbles
        words = '{10,10,10,10, 5,5,5,5, 7,7,7,7};
        run_search("basic", 3, 0);
        run_search("bubbles", 3, 1);

        set_const(2, 1023);
        run_search("tie_max", 2, 0);

        // sad_valid while idle must not disturb anything
        ms = min_sad;
        sad_valid = 1'b1;
        repeat (4) begin
            sad_in = 10'($urandom);
            tick();
        end
        sad_valid = 1'b0;
        check("idle.busy", busy, 0);
        check("idle.ready", sad_ready, 0);
        check("idle.min_sad", min_sad, ms);
        words = '{3,3,3,3};
        run_search("idle_then_run", 1, 0);

        // restart after 6 words; valid word held on the restart edge is discarded
        d0 = done_cnt;
        start = 1'b1; num_cand = 8'd3;
        tick();
        start = 1'b0;
        sad_valid = 1'b1; sad_in = 10'd0;
        repeat (6) tick();
        sad_in = 10'd0;
        set_const(1, 2);
        run_search("restart", 1, 0);
        check("restart.single_done", done_cnt - d0, 1);

        run_search("zero_cand", 0, 0);

        // randomized searches
        for (int t = 0; t < 8; t++) begin
            int n;
            n = 1 + int'($urandom % 5);
            words.delete();
            for (int i = 0; i < n*BW; i++)
                words.push_back(($urandom % 4 == 0) ? 1023 : int'($urandom % 1024));
            run_search($sformatf("rand%0d", t), n, int'($urandom % 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
